// File: rtl/dc_dac_pkg.sv
// Shared types and constants for the DC DAC path (dispatcher and SPI writer).
package dc_dac_pkg;

    localparam int unsigned DAC_CHANNEL  = 24;
    localparam int unsigned DC_WORD_BITS = 24;
    localparam int unsigned CH_W         = 5;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/spi_word_shifter.sv
// Shifts one word out MSB first as a single CPOL=0 SPI transaction:
// chip-select setup, WORD_BITS clock periods, chip-select hold.
module spi_word_shifter #(
    parameter int unsigned WORD_BITS = 24,
    parameter int unsigned SCLK_DIV  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WORD_BITS-1:0] i_word,
    output logic                 o_sclk,
    output logic                 o_mosi,
    output logic                 o_cs_active,
    output logic                 o_done_c
);
    import dc_dac_pkg::*;

    localparam int unsigned DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned HALF_W = $clog2(2 * WORD_BITS);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * WORD_BITS - 1);

    state_t                phase_q, phase_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [HALF_W-1:0]     half_q, half_d;
    logic [WORD_BITS-1:0]  sh_q, sh_d;
    logic                  sclk_q, sclk_d;
    logic                  act_q, act_d;
    logic                  div_last_c;
    logic                  half_last_c;

    // End-of-half-period and end-of-word flags
    always_comb begin
        div_last_c  = (div_q == DIV_LAST);
        half_last_c = (half_q == HALF_LAST);
        o_done_c    = (phase_q == CS_HOLD) && div_last_c;
    end

    // Phase register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_q <= IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Next phase: setup -> shift -> hold, each advancing on divider wrap
    always_comb begin
        phase_d = phase_q;
        if (i_start) begin
            phase_d = CS_SETUP;
        end else begin
            case (phase_q)
                CS_SETUP: if (div_last_c) phase_d = SHIFT;
                SHIFT:    if (div_last_c && half_last_c) phase_d = CS_HOLD;
                CS_HOLD:  if (div_last_c) phase_d = IDLE;
                default:  phase_d = IDLE;
            endcase
        end
    end

    // Divider, half-period count, SCLK and shift register; MOSI moves on falling SCLK
    always_comb begin
        div_d  = '0;
        half_d = '0;
        sh_d   = sh_q;
        sclk_d = 1'b0;
        act_d  = (phase_d != IDLE);
        if (!i_start && (phase_q != IDLE) && !div_last_c) begin
            div_d = div_q + DIV_W'(1);
        end
        if (!i_start && (phase_q == SHIFT)) begin
            half_d = div_last_c ? (half_q + HALF_W'(1)) : half_q;
        end
        if (i_start) begin
            sh_d = i_word;
        end else begin
            case (phase_q)
                CS_SETUP: sclk_d = div_last_c;
                SHIFT: begin
                    sclk_d = sclk_q;
                    if (div_last_c) begin
                        sclk_d = half_last_c ? 1'b0 : ~sclk_q;
                        if (sclk_q) begin
                            sh_d = sh_q << 1;
                        end
                    end
                end
                default: sclk_d = 1'b0;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_q  <= '0;
            half_q <= '0;
            sh_q   <= '0;
            sclk_q <= 1'b0;
            act_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            half_q <= half_d;
            sh_q   <= sh_d;
            sclk_q <= sclk_d;
            act_q  <= act_d;
        end
    end

    assign o_sclk      = sclk_q;
    assign o_mosi      = sh_q[WORD_BITS-1];
    assign o_cs_active = act_q;

endmodule

// File: rtl/dc_dac_spi_writer.sv
// Latches a validated DC frame and writes each payload word to the selected
// DAC as its own SPI transaction; frames arriving while busy are dropped.
module dc_dac_spi_writer #(
    parameter int unsigned DAC_CHANNEL   = dc_dac_pkg::DAC_CHANNEL,
    parameter int unsigned PAYLOAD_WORDS = 61,
    parameter int unsigned WORD_BITS     = dc_dac_pkg::DC_WORD_BITS,
    parameter int unsigned SCLK_DIV      = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [PAYLOAD_WORDS-1:0][31:0] i_dc_regs,
    input  logic [4:0]                     i_channel_sel,
    input  logic                           i_valid_frame,
    output logic                           o_sclk,
    output logic                           o_mosi,
    output logic [DAC_CHANNEL-1:0]         o_cs_n,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_drop,
    output logic                           o_err
);
    import dc_dac_pkg::*;

    localparam int unsigned IDX_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam int unsigned GAP_W = $clog2(2 * SCLK_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * SCLK_DIV - 1);

    // Top-level SHIFT spans the shifter-owned setup/shift/hold of one word
    state_t                                   state_q, state_d;
    logic [PAYLOAD_WORDS-1:0][WORD_BITS-1:0]  regs_q, regs_d;
    logic [CH_W-1:0]                          chan_q, chan_d;
    logic [IDX_W-1:0]                         idx_q, idx_d;
    logic [GAP_W-1:0]                         gap_q, gap_d;
    logic [DAC_CHANNEL-1:0]                   cs_n_q, cs_n_d;
    logic                                     busy_q, busy_d;
    logic                                     done_q, done_d;
    logic                                     drop_q, drop_d;
    logic                                     err_q, err_d;

    logic                  accept_c;
    logic                  chan_ok_c;
    logic                  gap_end_c;
    logic                  last_word_c;
    logic                  start_c;
    logic [CH_W-1:0]       start_chan_c;
    logic [WORD_BITS-1:0]  start_word_c;
    logic                  unused_c;

    logic sh_sclk;
    logic sh_mosi;
    logic sh_cs_active;
    logic sh_done_c;

    // Frame acceptance, channel check and word sequencing decodes
    always_comb begin
        accept_c     = i_valid_frame && ((state_q == IDLE) || (state_q == DONE));
        chan_ok_c    = (32'(i_channel_sel) < DAC_CHANNEL);
        gap_end_c    = (state_q == GAP) && (gap_q == GAP_LAST);
        last_word_c  = (idx_q == LAST_IDX);
        start_c      = (accept_c && chan_ok_c) || (gap_end_c && !last_word_c);
        start_chan_c = accept_c ? i_channel_sel : chan_q;
        start_word_c = accept_c ? i_dc_regs[0][WORD_BITS-1:0] : regs_q[idx_q + IDX_W'(1)];
        unused_c     = ^i_dc_regs;
    end

    spi_word_shifter #(
        .WORD_BITS (WORD_BITS),
        .SCLK_DIV  (SCLK_DIV)
    ) u_shifter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (start_c),
        .i_word      (start_word_c),
        .o_sclk      (sh_sclk),
        .o_mosi      (sh_mosi),
        .o_cs_active (sh_cs_active),
        .o_done_c    (sh_done_c)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: word in flight -> inter-word gap -> next word or done
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = (accept_c && chan_ok_c) ? SHIFT : IDLE;
            SHIFT:      if (sh_done_c) state_d = GAP;
            GAP:        if (gap_end_c) state_d = last_word_c ? DONE : SHIFT;
            default:    state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        regs_d = regs_q;
        chan_d = chan_q;
        idx_d  = idx_q;
        gap_d  = '0;
        cs_n_d = '1;
        busy_d = (state_d == SHIFT) || (state_d == GAP);
        done_d = (state_d == DONE);
        drop_d = i_valid_frame && ((state_q == SHIFT) || (state_q == GAP));
        err_d  = accept_c && !chan_ok_c;
        if (accept_c) begin
            for (int unsigned w = 0; w < PAYLOAD_WORDS; w++) begin
                regs_d[w] = i_dc_regs[w][WORD_BITS-1:0];
            end
            chan_d = i_channel_sel;
            idx_d  = '0;
        end
        if ((state_q == GAP) && !gap_end_c) begin
            gap_d = gap_q + GAP_W'(1);
        end
        if (gap_end_c && !last_word_c) begin
            idx_d = idx_q + IDX_W'(1);
        end
        if (start_c) begin
            for (int unsigned i = 0; i < DAC_CHANNEL; i++) begin
                if (CH_W'(i) == start_chan_c) begin
                    cs_n_d[i] = 1'b0;
                end
            end
        end else if (sh_cs_active && !sh_done_c) begin
            cs_n_d = cs_n_q;
        end
    end

    // Output and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            regs_q <= '0;
            chan_q <= '0;
            idx_q  <= '0;
            gap_q  <= '0;
            cs_n_q <= '1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            drop_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            chan_q <= chan_d;
            idx_q  <= idx_d;
            gap_q  <= gap_d;
            cs_n_q <= cs_n_d;
            busy_q <= busy_d;
            done_q <= done_d;
            drop_q <= drop_d;
            err_q  <= err_d;
        end
    end

    assign o_sclk = sh_sclk;
    assign o_mosi = sh_mosi;
    assign o_cs_n = cs_n_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_drop = drop_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_dc_dac_spi_writer.sv
// Randomised bench for dc_dac_spi_writer against a cycle-offset timing model.
module tb_dc_dac_spi_writer;

    localparam int unsigned DAC = 24;
    localparam int unsigned PW  = 2;
    localparam int unsigned WB  = 24;
    localparam int unsigned DIV = 2;
    localparam int WORD_CYC  = (2 * WB + 4) * DIV;
    localparam int CS_CYC    = (2 * WB + 2) * DIV;
    localparam int FRAME_CYC = PW * WORD_CYC;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic [PW-1:0][31:0]  i_dc_regs = '0;
    logic [4:0]           i_channel_sel = '0;
    logic                 i_valid_frame = 1'b0;
    logic                 o_sclk;
    logic                 o_mosi;
    logic [DAC-1:0]       o_cs_n;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_drop;
    logic                 o_err;

    dc_dac_spi_writer #(
        .DAC_CHANNEL   (DAC),
        .PAYLOAD_WORDS (PW),
        .WORD_BITS     (WB),
        .SCLK_DIV      (DIV)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_dc_regs     (i_dc_regs),
        .i_channel_sel (i_channel_sel),
        .i_valid_frame (i_valid_frame),
        .o_sclk        (o_sclk),
        .o_mosi        (o_mosi),
        .o_cs_n        (o_cs_n),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_drop        (o_drop),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: one active frame described by its start cycle
    bit                  has_frame = 1'b0;
    int                  fa        = 0;
    int                  fch       = 0;
    logic [PW-1:0][31:0] fw        = '0;
    int                  drop_at   = -1;
    int                  err_at    = -1;
    logic [31:0]         exp_q[$];

    // Independent SPI decoder state
    logic [31:0] dec       = '0;
    int          nbits     = 0;
    int          win       = 0;
    bit          prev_low  = 1'b0;
    bit          prev_sclk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    endtask

    function automatic bit model_busy(input int k);
        return has_frame && (k >= fa) && (k < fa + FRAME_CYC);
    endfunction

    // Drive one cycle of inputs, advance the model, then check outputs
    task automatic step(input bit rst, input bit v, input logic [4:0] sel,
                        input logic [PW-1:0][31:0] w);
        logic [DAC-1:0] e_cs;
        bit             e_busy, e_done, e_sclk, e_mosi, mosi_chk, cs_low;
        int             off, wi, o, h;
        logic [31:0]    ew;
        i_rst         = rst;
        i_valid_frame = v;
        i_channel_sel = sel;
        i_dc_regs     = w;
        if (rst) begin
            has_frame = 1'b0;
            drop_at   = -1;
            err_at    = -1;
            exp_q.delete();
        end else if (v) begin
            if (model_busy(cyc)) begin
                drop_at = cyc + 1;
            end else if (32'(sel) >= DAC) begin
                err_at = cyc + 1;
            end else begin
                has_frame = 1'b1;
                fa  = cyc + 1;
                fch = int'(sel);
                fw  = w;
                for (int p = 0; p < PW; p++) exp_q.push_back(w[p] & 32'h00FF_FFFF);
            end
        end
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);

        e_cs = '1; e_busy = 0; e_done = 0; e_sclk = 0; e_mosi = 0; mosi_chk = 0;
        if (has_frame && cyc >= fa && cyc <= fa + FRAME_CYC) begin
            off = cyc - fa;
            if (off == FRAME_CYC) begin
                e_done = 1'b1;
            end else begin
                wi = off / WORD_CYC;
                o  = off % WORD_CYC;
                e_busy = 1'b1;
                if (o < CS_CYC) e_cs[fch] = 1'b0;
                if (o < DIV) begin
                    mosi_chk = 1'b1;
                    e_mosi   = fw[wi][WB-1];
                end else if (o < DIV + 2 * WB * DIV) begin
                    h = (o - DIV) / DIV;
                    e_sclk = ((h % 2) == 0);
                    if (h < 2 * WB - 1) begin
                        mosi_chk = 1'b1;
                        e_mosi   = fw[wi][WB - 1 - (h + 1) / 2];
                    end
                end
            end
        end
        chk("cs_n", 32'(o_cs_n), 32'(e_cs));
        chk("ctl", {27'b0, o_busy, o_done, o_drop, o_err, o_sclk},
                   {27'b0, e_busy, e_done, cyc == drop_at, cyc == err_at, e_sclk});
        if (mosi_chk) chk("mosi", 32'(o_mosi), 32'(e_mosi));

        cs_low = ~&o_cs_n;
        if (rst) begin
            dec = '0; nbits = 0; win = 0;
        end else if (cs_low) begin
            if (!prev_low) begin
                dec = '0; nbits = 0; win = 0;
            end
            win++;
            if (!prev_sclk && o_sclk) begin
                dec = {dec[30:0], o_mosi};
                nbits++;
            end
        end else if (prev_low) begin
            chk("pending_words", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                ew = exp_q.pop_front();
                chk("word", dec, ew);
                chk("bits", 32'(nbits), 32'(WB));
                chk("cs_window", 32'(win), 32'(CS_CYC));
            end
        end
        prev_low  = rst ? 1'b0 : cs_low;
        prev_sclk = o_sclk;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, i_dc_regs);
    endtask

    function automatic logic [PW-1:0][31:0] rnd_words();
        logic [PW-1:0][31:0] r;
        for (int p = 0; p < PW; p++) r[p] = $urandom();
        return r;
    endfunction

    initial begin
        logic [PW-1:0][31:0] w;
        logic [PW-1:0][31:0] w2;
        logic [4:0]          sel;
        int                  r;
        w = '0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, w);
        chk("rst_mosi", 32'(o_mosi), 32'(0));
        idle(2);

        // Known words on channel 5
        w[0] = 32'h00AB_CDEF;
        w[1] = 32'hFF12_3456;
        step(1'b0, 1'b1, 5'd5, w);
        idle(FRAME_CYC + 4);

        // Highest and lowest channel
        w = rnd_words();
        step(1'b0, 1'b1, 5'd23, w);
        idle(FRAME_CYC + 3);
        w = rnd_words();
        step(1'b0, 1'b1, 5'd0, w);
        idle(FRAME_CYC + 3);

        // Out-of-range channels
        for (int s = 24; s < 32; s++) begin
            step(1'b0, 1'b1, 5'(s), rnd_words());
            idle(2);
        end

        // Frame arriving ten cycles into a transfer
        w  = rnd_words();
        w2 = rnd_words();
        step(1'b0, 1'b1, 5'd7, w);
        idle(9);
        step(1'b0, 1'b1, 5'd3, w2);
        idle(FRAME_CYC + 4);

        // Second frame coincident with the done cycle, then one a cycle early
        step(1'b0, 1'b1, 5'd12, rnd_words());
        while (cyc < fa + FRAME_CYC) idle(1);
        step(1'b0, 1'b1, 5'd13, rnd_words());
        while (cyc < fa + FRAME_CYC - 1) idle(1);
        step(1'b0, 1'b1, 5'd14, rnd_words());
        idle(3);

        // Reset in the middle of SHIFT
        step(1'b0, 1'b1, 5'd9, rnd_words());
        idle(30);
        step(1'b1, 1'b0, 5'd0, i_dc_regs);
        idle(FRAME_CYC + 10);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            sel = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(24, 31))
                                              : 5'($urandom_range(0, 23));
            step(r == 0, r < 8, sel, rnd_words());
        end
        idle(FRAME_CYC + 10);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dc_dac_spi_writer.md
# dc_dac_spi_writer

Downstream of the DC frame dispatcher. Captures a validated DC frame (payload words plus decoded channel select) and serialises each payload word to the addressed DAC as one SPI transaction. Each word gets its own chip-select pulse, and only the selected channel's chip select is driven. Frames that arrive while a transfer is in progress are dropped and flagged; they are never queued.

## Interface
- `DAC_CHANNEL`, default 24: number of DAC chip selects.
- `PAYLOAD_WORDS`, default 61: payload words per frame, indexed 0..PAYLOAD_WORDS-1.
- `WORD_BITS`, default 24: bits shifted per word, taken from the word's LSBs.
- `SCLK_DIV`, default 2: SCLK half-period in `i_clk` cycles; must be at least 1.

- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_dc_regs`  in  [PAYLOAD_WORDS-1:0][31:0]  frame payload; valid in the `i_valid_frame` cycle only.
- `i_channel_sel`  in  5  target DAC index; valid in the `i_valid_frame` cycle only.
- `i_valid_frame`  in  1  one-cycle strobe: frame ready.
- `o_sclk`  out  1  SPI clock, CPOL=0.
- `o_mosi`  out  1  SPI data, MSB first.
- `o_cs_n`  out  [DAC_CHANNEL-1:0]  active-low chip selects; at most one is low at any time.
- `o_busy`  out  1  a transfer is in progress.
- `o_done`  out  1  one-cycle pulse: the last word of the frame has been sent.
- `o_drop`  out  1  one-cycle pulse: a frame was received while busy and was discarded.
- `o_err`  out  1  one-cycle pulse: `i_channel_sel` was at least DAC_CHANNEL; frame rejected.

## Operation
- All outputs are registered.
- Reset values: `o_sclk`=0, `o_mosi`=0, `o_cs_n`=all ones, `o_busy`=0, `o_done`=0, `o_drop`=0, `o_err`=0. Word index, bit counter and divider counter reset to 0.
- A frame is accepted when `i_valid_frame`=1 and the state is IDLE or DONE.
  - On acceptance, latch the full payload and the channel select.
  - If `i_channel_sel` ≥ DAC_CHANNEL: pulse `o_err`, stay in IDLE, drive no chip select.
- States:
  - IDLE: waits for a frame.
  - CS_SETUP (SCLK_DIV cycles): selected `o_cs_n` low, `o_sclk` low, `o_mosi` = bit WORD_BITS-1 of the current word.
  - SHIFT (WORD_BITS × 2·SCLK_DIV cycles): `o_sclk` toggles every SCLK_DIV cycles. `o_mosi` updates on each falling edge to the next lower bit and is therefore stable across every rising edge.
  - CS_HOLD (SCLK_DIV cycles): `o_sclk` low, chip select still low.
  - GAP (2·SCLK_DIV cycles): all `o_cs_n` high. Then, if more words remain, go to CS_SETUP with the word index incremented; otherwise go to DONE.
  - DONE (1 cycle): `o_done`=1, `o_busy`=0, then return to IDLE.
- `o_busy`=1 in CS_SETUP, SHIFT, CS_HOLD and GAP.
- `i_valid_frame` while busy: pulse `o_drop` in the next cycle. The current transfer and its latched data are unaffected.
- `i_rst` mid-transfer: on the next edge all `o_cs_n` go high, `o_sclk`=0, and the state returns to IDLE. No `o_done` is produced.
- Bits 31:WORD_BITS of each payload word are ignored.

## Timing
- `i_valid_frame` sampled high at edge N: at edge N+1 `o_busy`=1, the selected `o_cs_n`=0 and `o_mosi` holds the first MSB.
- First `o_sclk` rising edge occurs at edge N+1+SCLK_DIV.
- Each word occupies (2·WORD_BITS + 4)·SCLK_DIV cycles. With the defaults this is 104 cycles.
- `o_done` is high in cycle N+1+PAYLOAD_WORDS·(2·WORD_BITS+4)·SCLK_DIV.
- A new `i_valid_frame` coincident with the `o_done` cycle is accepted; its chip select goes low on the following edge.
- `o_drop`, `o_err` and `o_done` each rise one cycle after their cause and last exactly one cycle.

## Structure
- Package `dc_dac_pkg`: the state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, DONE) and the shared constants DAC_CHANNEL=24 and DC_WORD_BITS=24, also used by the dispatcher.
- Sub-module `spi_word_shifter`:
  - Inputs: start, word, WORD_BITS, SCLK_DIV.
  - Outputs: sclk, mosi, cs_active, done.
  - Owns CS_SETUP, SHIFT and CS_HOLD timing.
- The top level owns the frame latch, word index, GAP/DONE sequencing, channel decode and the drop/err flags.

## Test plan
- PAYLOAD_WORDS=2, SCLK_DIV=2, channel 5, words 0x00ABCDEF and 0xFF123456 → `o_cs_n[5]` has two low windows of 100 cycles each. The MOSI bits sampled at SCLK rising edges decode to 0xABCDEF then 0x123456. `o_done` is high at N+1+208.
- Channel 23 vs channel 0 → only the matching `o_cs_n` bit ever goes low; all other bits stay high throughout.
- `i_channel_sel`=24 → `o_err` pulses at N+1; `o_cs_n` stays all ones; `o_busy` stays 0.
- Second `i_valid_frame` 10 cycles into a transfer → `o_drop` pulses once; the first frame's data completes unchanged; exactly one `o_done`.
- Back-to-back frames with the second `i_valid_frame` in the `o_done` cycle → the second frame starts on the next edge with no drop.
- `i_rst` asserted mid-SHIFT → next edge gives `o_cs_n` all ones, `o_sclk`=0, `o_busy`=0; no `o_done` before the next frame.
